// File: rtl/ecm_synth_frame_collector.sv
// Ping-pong frame collector: gathers one frame of indexed I/Q samples in any order,
// then replays it in strict index order while the other bank fills.
package ecm_synth_frame_collector_pkg;
  localparam int ecm_num_channels = 6;
  localparam int ecm_synthesizer_data_width = 16;
  localparam int ecm_channel_index_width = $clog2(ecm_num_channels);

  typedef struct packed {
    logic                               valid;
    logic                               last;
    logic [ecm_channel_index_width-1:0] data_index;
  } channelizer_control_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } rd_state_t;
endpackage

module ecm_synth_frame_collector
  import ecm_synth_frame_collector_pkg::*;
#(
  parameter int NUM_CHANNELS = ecm_num_channels,
  parameter int DATA_WIDTH   = ecm_synthesizer_data_width
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  channelizer_control_t         Input_ctrl,
  input  logic signed [DATA_WIDTH-1:0] Input_data [2],
  output channelizer_control_t         Output_ctrl,
  output logic signed [DATA_WIDTH-1:0] Output_data [2],
  output logic                         Error_missing,
  output logic                         Error_duplicate,
  output logic                         Error_overflow,
  output logic                         Error_index,
  output rd_state_t                    Debug_rd_state
);
  localparam int IW = ecm_channel_index_width;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHANNELS - 1);

  // Valid/ready: there is no back-pressure; a sample is taken whenever Input_ctrl.valid
  // is high, and Output_ctrl.valid marks one sample per cycle with no ready to wait on.
  logic signed [DATA_WIDTH-1:0] mem_i [2][NUM_CHANNELS];
  logic signed [DATA_WIDTH-1:0] mem_q [2][NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]      mask  [2];
  logic [1:0]                   full;
  logic                         wr;
  logic                         rd;
  rd_state_t                    state;
  logic [IW-1:0]                rd_idx;

  logic                    idx_ok;
  logic                    accept;
  logic                    close;
  logic                    draining;
  logic                    drain_done;
  logic [NUM_CHANNELS-1:0] wr_bit;
  logic [NUM_CHANNELS-1:0] mask_next;

  always_comb begin
    idx_ok     = int'(Input_ctrl.data_index) < NUM_CHANNELS;
    wr_bit     = NUM_CHANNELS'(1) << Input_ctrl.data_index;
    accept     = Input_ctrl.valid && idx_ok && !full[wr];
    close      = accept && Input_ctrl.last;
    mask_next  = mask[wr] | wr_bit;
    draining   = full[rd];
    drain_done = full[rd] && (rd_idx == LAST_IDX);
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      mem_i[wr][Input_ctrl.data_index] <= Input_data[0];
      mem_q[wr][Input_ctrl.data_index] <= Input_data[1];
    end
  end

  // Close and drain always touch different banks: a close needs full[wr]==0 while a
  // drain needs full[rd]==1, so the per-bank updates below never collide.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      full            <= '0;
      mask[0]         <= '0;
      mask[1]         <= '0;
      wr              <= 1'b0;
      rd              <= 1'b0;
      state           <= S_IDLE;
      rd_idx          <= '0;
      Output_ctrl     <= '0;
      Output_data[0]  <= '0;
      Output_data[1]  <= '0;
      Error_missing   <= 1'b0;
      Error_duplicate <= 1'b0;
      Error_overflow  <= 1'b0;
      Error_index     <= 1'b0;
    end else begin
      Error_duplicate <= accept && |(mask[wr] & wr_bit);
      Error_index     <= Input_ctrl.valid && !idx_ok;
      Error_overflow  <= Input_ctrl.valid && idx_ok && full[wr];
      Error_missing   <= close && (mask_next != '1);

      if (accept) mask[wr] <= mask_next;
      if (close) begin
        full[wr] <= 1'b1;
        wr       <= ~wr;
      end

      Output_ctrl.valid      <= draining;
      Output_ctrl.last       <= draining && (rd_idx == LAST_IDX);
      Output_ctrl.data_index <= rd_idx;
      Output_data[0] <= (draining && mask[rd][rd_idx]) ? mem_i[rd][rd_idx] : '0;
      Output_data[1] <= (draining && mask[rd][rd_idx]) ? mem_q[rd][rd_idx] : '0;

      // A freed bank gets its mask cleared here, so it is clean before it is written.
      if (drain_done) begin
        full[rd] <= 1'b0;
        mask[rd] <= '0;
        rd       <= ~rd;
        rd_idx   <= '0;
        state    <= (full[~rd] || (close && (wr == ~rd))) ? S_READ : S_IDLE;
      end else if (draining) begin
        rd_idx <= rd_idx + 1'b1;
        state  <= S_READ;
      end else begin
        state <= S_IDLE;
      end
    end
  end

  assign Debug_rd_state = state;
endmodule

// File: tb/tb_ecm_synth_frame_collector.sv
// Bench for ecm_synth_frame_collector: directed frames plus random traffic, checked
// cycle by cycle against a frame-queue reference model.
module tb_ecm_synth_frame_collector;
  import ecm_synth_frame_collector_pkg::*;

  localparam int N  = ecm_num_channels;
  localparam int DW = ecm_synthesizer_data_width;
  localparam int IW = ecm_channel_index_width;

  logic                 Clk = 1'b0;
  logic                 Rst = 1'b1;
  channelizer_control_t in_ctrl = '0;
  logic signed [DW-1:0] in_data [2];
  channelizer_control_t out_ctrl;
  logic signed [DW-1:0] out_data [2];
  logic                 err_missing, err_duplicate, err_overflow, err_index;
  rd_state_t            dbg_state;

  always #5 Clk = ~Clk;

  ecm_synth_frame_collector dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Input_ctrl      (in_ctrl),
    .Input_data      (in_data),
    .Output_ctrl     (out_ctrl),
    .Output_data     (out_data),
    .Error_missing   (err_missing),
    .Error_duplicate (err_duplicate),
    .Error_overflow  (err_overflow),
    .Error_index     (err_index),
    .Debug_rd_state  (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: completed frames wait in exp_q in arrival order; the head frame
  // is replayed one index per cycle. A sample is dropped when two frames are pending.
  typedef struct packed {
    logic [N-1:0]         mask;
    logic [N-1:0][DW-1:0] i_v;
    logic [N-1:0][DW-1:0] q_v;
  } frame_t;

  frame_t               cur;
  frame_t               exp_q[$];
  int                   pos;
  logic                 e_valid, e_last, e_miss, e_dup, e_ovf, e_idxerr;
  logic [IW-1:0]        e_idx;
  logic signed [DW-1:0] e_i, e_q;

  task automatic model_step(input logic rst, input logic v, input logic l, input int idx,
                            input logic signed [DW-1:0] di, input logic signed [DW-1:0] dq);
    int     n_pre;
    frame_t f;
    e_miss = 0; e_dup = 0; e_ovf = 0; e_idxerr = 0;
    if (rst) begin
      cur = '0; exp_q.delete(); pos = 0;
      e_valid = 0; e_last = 0; e_idx = '0; e_i = '0; e_q = '0;
      return;
    end
    n_pre = exp_q.size();
    if (n_pre > 0) begin
      f       = exp_q[0];
      e_valid = 1;
      e_idx   = IW'(pos);
      e_last  = (pos == N - 1);
      e_i     = f.mask[pos] ? f.i_v[pos] : '0;
      e_q     = f.mask[pos] ? f.q_v[pos] : '0;
      pos++;
      if (pos == N) begin
        void'(exp_q.pop_front());
        pos = 0;
      end
    end else begin
      e_valid = 0;
    end
    if (v) begin
      if (idx >= N) e_idxerr = 1;
      else if (n_pre == 2) e_ovf = 1;
      else begin
        if (cur.mask[idx]) e_dup = 1;
        cur.mask[idx] = 1'b1;
        cur.i_v[idx]  = di;
        cur.q_v[idx]  = dq;
        if (l) begin
          if (cur.mask != '1) e_miss = 1;
          exp_q.push_back(cur);
          cur = '0;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic l, input int idx, input int di, input int dq,
                      input logic rst = 1'b0);
    @(negedge Clk);
    Rst                = rst;
    in_ctrl.valid      = v;
    in_ctrl.last       = l;
    in_ctrl.data_index = IW'(idx);
    in_data[0]         = DW'(di);
    in_data[1]         = DW'(dq);
    @(posedge Clk);
    model_step(rst, v, l, idx, DW'(di), DW'(dq));
    #1;
    check_val("out_valid", out_ctrl.valid, e_valid);
    if (e_valid) begin
      check_val("out_idx", out_ctrl.data_index, e_idx);
      check_val("out_last", out_ctrl.last, e_last);
      check_val("out_i", out_data[0], e_i);
      check_val("out_q", out_data[1], e_q);
    end
    check_val("err_missing", err_missing, e_miss);
    check_val("err_duplicate", err_duplicate, e_dup);
    check_val("err_overflow", err_overflow, e_ovf);
    check_val("err_index", err_index, e_idxerr);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  task automatic send_frame_in_order(input int base);
    for (int k = 0; k < N; k++) step(1, k == N - 1, k, base + k, -(base + k));
  endtask

  initial begin
    in_data[0] = '0;
    in_data[1] = '0;
    step(0, 0, 0, 0, 0, 1'b1);
    step(0, 0, 0, 0, 0, 1'b1);
    check_val("reset_state", dbg_state, S_IDLE);
    idle(2);

    // In-order frame, I=idx, Q=-idx
    send_frame_in_order(0);
    idle(N + 3);

    // Reversed order, last on index 0
    for (int k = N - 1; k >= 0; k--) step(1, k == 0, k, 100 + k, -(100 + k));
    idle(N + 3);

    // Missing index 3, duplicate index 5 with second write I=77
    step(1, 0, 0, 10, -10);
    step(1, 0, 1, 11, -11);
    step(1, 0, 2, 12, -12);
    step(1, 0, 5, 15, -15);
    step(1, 0, 4, 14, -14);
    step(1, 1, 5, 77, -77);
    idle(N + 3);

    // Back-to-back frames at one sample per cycle
    for (int fr = 0; fr < 4; fr++) send_frame_in_order(200 + 10 * fr);
    idle(N + 3);

    // Fill both banks with short frames, then a burst that must be dropped
    send_frame_in_order(300);
    step(1, 1, 2, 401, -401);
    step(1, 1, 1, 402, -402);
    for (int k = 0; k < 4; k++) step(1, k == 3, k, 500 + k, -(500 + k));
    idle(2 * N + 3);

    // Reset mid-frame, then mid-drain
    for (int k = 0; k < 3; k++) step(1, 0, k, 600 + k, -(600 + k));
    step(0, 0, 0, 0, 0, 1'b1);
    idle(N + 2);
    send_frame_in_order(700);
    idle(2);
    step(0, 0, 0, 0, 0, 1'b1);
    idle(N + 2);
    send_frame_in_order(800);
    idle(N + 3);

    // Random traffic, including out-of-range indices and occasional resets
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7),
           $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 99) == 0);
    end
    idle(2 * N + 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
